// File: rtl/group_dispatcher_pkg.sv
// Shared group-path constants: dispatcher defaults, FSM encoding, group FIFO sizing.
package group_dispatcher_pkg;

  localparam int unsigned BANKS_DEF      = 4;
  localparam int unsigned GID_WIDTH_DEF  = 16;
  localparam int unsigned CNT_WIDTH_DEF  = 32;

  // Upstream group FIFO sizing, shared with the FIFO block.
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned FIFO_AW_DEF    = $clog2(FIFO_DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_POP      = 2'd1,
    ST_WAIT     = 2'd2,
    ST_DISPATCH = 2'd3
  } state_e;

endpackage

// File: rtl/group_dispatcher_if.sv
// Group FIFO handshake, bank engine start/done and status bundle.
interface group_dispatcher_if import group_dispatcher_pkg::*; #(
  parameter int unsigned BANKS     = BANKS_DEF,
  parameter int unsigned GID_WIDTH = GID_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
);

  logic                       fifo_peek_valid;
  logic                       fifo_pop_ready;
  logic                       fifo_pop_valid;
  logic [GID_WIDTH-1:0]       fifo_pop_gid;
  logic [BANKS-1:0]           bank_start;
  logic [BANKS*GID_WIDTH-1:0] bank_gid;
  logic [BANKS-1:0]           bank_done;
  logic [BANKS-1:0]           busy_mask;
  logic [CNT_WIDTH-1:0]       dispatch_count;
  logic [CNT_WIDTH-1:0]       complete_count;
  logic                       err_spurious;

  // Dispatcher side.
  modport master (
    input  fifo_peek_valid, fifo_pop_valid, fifo_pop_gid, bank_done,
    output fifo_pop_ready, bank_start, bank_gid, busy_mask,
           dispatch_count, complete_count, err_spurious
  );

  // FIFO / bank-engine side.
  modport slave (
    output fifo_peek_valid, fifo_pop_valid, fifo_pop_gid, bank_done,
    input  fifo_pop_ready, bank_start, bank_gid, busy_mask,
           dispatch_count, complete_count, err_spurious
  );

endinterface

// File: rtl/group_dispatcher_rr_idle_select.sv
// Rotating first-idle finder: lowest idle bank at or above rr_ptr, wrapping.
module rr_idle_select import group_dispatcher_pkg::*; #(
  parameter int unsigned BANKS = BANKS_DEF
) (
  input  logic [BANKS-1:0]         idle_i,
  input  logic [$clog2(BANKS)-1:0] rr_ptr_i,
  output logic                     found_o,
  output logic [$clog2(BANKS)-1:0] index_o
);

  localparam int unsigned IDX_W = $clog2(BANKS);

  logic             found;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] pos;

  // Scan BANKS positions from rr_ptr; power-of-two BANKS makes the wrap free.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int unsigned k = 0; k < BANKS; k++) begin
      pos = rr_ptr_i + IDX_W'(k);
      if (!found && idle_i[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

  assign found_o = found;
  assign index_o = index;

endmodule

// File: rtl/group_dispatcher.sv
// Pops group ids from the upstream FIFO and starts them on idle bank engines round-robin.
module group_dispatcher import group_dispatcher_pkg::*; #(
  parameter int unsigned BANKS     = BANKS_DEF,
  parameter int unsigned GID_WIDTH = GID_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  group_dispatcher_if.master bus
);

  localparam int unsigned IDX_W = $clog2(BANKS);
  localparam int unsigned POP_W = $clog2(BANKS + 1);

  state_e                     state_q, state_d;
  logic                       pop_ready_q, pop_ready_d;
  logic [BANKS-1:0]           start_q, start_d;
  logic [BANKS-1:0]           busy_q, busy_d;
  logic [IDX_W-1:0]           sel_idx_q, sel_idx_d;
  logic [IDX_W-1:0]           rr_q, rr_d;
  logic [GID_WIDTH-1:0]       hold_q, hold_d;
  logic [BANKS*GID_WIDTH-1:0] gid_q, gid_d;
  logic [CNT_WIDTH-1:0]       disp_q, disp_d;
  logic [CNT_WIDTH-1:0]       comp_q, comp_d;
  logic                       err_q, err_d;

  logic [BANKS-1:0]           done_ok;
  logic [BANKS-1:0]           done_bad;
  logic [POP_W-1:0]           done_cnt;
  logic                       start_now;
  logic                       nxt_found;
  logic [IDX_W-1:0]           nxt_idx;

  // start_q is only ever non-zero while in DISPATCH.
  assign start_now = |start_q;

  // FSM next state, hold capture, busy tracking and counters.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rr_d     = rr_q;
    disp_d   = disp_q;
    comp_d   = comp_q;
    err_d    = err_q;
    done_ok  = bus.bank_done & busy_q;
    done_bad = bus.bank_done & ~busy_q;
    done_cnt = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.fifo_peek_valid) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.fifo_pop_valid) begin
          hold_d  = bus.fifo_pop_gid;
          state_d = ST_DISPATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        if (start_now) begin
          rr_d    = sel_idx_q + IDX_W'(1);
          disp_d  = disp_q + CNT_WIDTH'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int unsigned b = 0; b < BANKS; b++) begin
      done_cnt = done_cnt + POP_W'(done_ok[b]);
    end
    busy_d = (busy_q & ~done_ok) | start_q;
    comp_d = comp_q + CNT_WIDTH'(done_cnt);
    if (|done_bad) err_d = 1'b1;
  end

  // Look ahead on next-cycle busy/rr so start and gid come out of flops;
  // a bank finishing this cycle is still busy now and only idle from busy_d.
  rr_idle_select #(.BANKS(BANKS)) u_sel (
    .idle_i   (~busy_d),
    .rr_ptr_i (rr_d),
    .found_o  (nxt_found),
    .index_o  (nxt_idx)
  );

  // Registered pop request, start pulse and per-bank gid.
  always_comb begin
    pop_ready_d = (state_d == ST_POP);
    start_d     = '0;
    sel_idx_d   = sel_idx_q;
    gid_d       = gid_q;
    if (state_d == ST_DISPATCH && nxt_found) begin
      start_d[nxt_idx]                               = 1'b1;
      sel_idx_d                                      = nxt_idx;
      gid_d[32'(nxt_idx) * GID_WIDTH +: GID_WIDTH]   = hold_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pop_ready_q <= 1'b0;
      start_q     <= '0;
      busy_q      <= '0;
      sel_idx_q   <= '0;
      rr_q        <= '0;
      hold_q      <= '0;
      gid_q       <= '0;
      disp_q      <= '0;
      comp_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pop_ready_q <= pop_ready_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      sel_idx_q   <= sel_idx_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      gid_q       <= gid_d;
      disp_q      <= disp_d;
      comp_q      <= comp_d;
      err_q       <= err_d;
    end
  end

  assign bus.fifo_pop_ready = pop_ready_q;
  assign bus.bank_start     = start_q;
  assign bus.bank_gid       = gid_q;
  assign bus.busy_mask      = busy_q;
  assign bus.dispatch_count = disp_q;
  assign bus.complete_count = comp_q;
  assign bus.err_spurious   = err_q;

endmodule

// File: tb/tb_group_dispatcher.sv
// Directed bench for group_dispatcher with a behavioural upstream group FIFO.
module tb_group_dispatcher;

  logic clk;
  logic rst_n;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] fifo_q[$];
  logic        withhold;

  group_dispatcher_if #(.BANKS(4), .GID_WIDTH(16), .CNT_WIDTH(32)) bus ();

  group_dispatcher #(.BANKS(4), .GID_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] slice(input int b);
    return bus.bank_gid[b*16 +: 16];
  endfunction

  // One clock: FIFO answers a pop request seen in the previous cycle, done pulses end.
  task automatic tick();
    logic pr;
    pr = bus.fifo_pop_ready;
    @(posedge clk);
    #1;
    bus.bank_done = '0;
    if (pr === 1'b1 && !withhold && fifo_q.size() > 0) begin
      bus.fifo_pop_valid = 1'b1;
      bus.fifo_pop_gid   = fifo_q.pop_front();
    end else begin
      bus.fifo_pop_valid = 1'b0;
      bus.fifo_pop_gid   = '0;
    end
    bus.fifo_peek_valid = (fifo_q.size() > 0);
  endtask

  task automatic push(input logic [15:0] g);
    fifo_q.push_back(g);
    bus.fifo_peek_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    withhold = 1'b0;
    fifo_q.delete();
    bus.fifo_peek_valid = 1'b0;
    bus.fifo_pop_valid  = 1'b0;
    bus.fifo_pop_gid    = '0;
    bus.bank_done       = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int budget, output logic [3:0] s, output int cyc);
    s   = '0;
    cyc = 0;
    while (s == 4'b0 && cyc < budget) begin
      tick();
      cyc++;
      s = bus.bank_start;
    end
  endtask

  initial begin
    logic [3:0] s;
    int         cyc;
    logic [3:0] any_start;

    rst_n = 1'b0;
    withhold = 1'b0;
    bus.fifo_peek_valid = 1'b0;
    bus.fifo_pop_valid  = 1'b0;
    bus.fifo_pop_gid    = '0;
    bus.bank_done       = '0;

    // Reset state
    do_reset();
    check("rst_pop_ready", 64'(bus.fifo_pop_ready), 64'd0);
    check("rst_start",     64'(bus.bank_start),     64'd0);
    check("rst_gid",       64'(bus.bank_gid),       64'd0);
    check("rst_busy",      64'(bus.busy_mask),      64'd0);
    check("rst_disp",      64'(bus.dispatch_count), 64'd0);
    check("rst_comp",      64'(bus.complete_count), 64'd0);
    check("rst_err",       64'(bus.err_spurious),   64'd0);

    // Two gids, all banks idle: bank0 then bank1, 4-cycle spacing
    push(16'h0011);
    push(16'h0022);
    wait_start(10, s, cyc);
    check("two_start0",    64'(s), 64'b0001);
    check("two_lat0",      64'(cyc), 64'd3);
    check("two_gid0",      64'(slice(0)), 64'h0011);
    wait_start(10, s, cyc);
    check("two_start1",    64'(s), 64'b0010);
    check("two_lat1",      64'(cyc), 64'd4);
    check("two_gid1",      64'(slice(1)), 64'h0022);
    check("two_gid0_hold", 64'(slice(0)), 64'h0011);
    tick();
    check("two_disp",      64'(bus.dispatch_count), 64'd2);
    check("two_busy",      64'(bus.busy_mask), 64'b0011);

    // Simultaneous completion on banks 0 and 1
    bus.bank_done = 4'b0011;
    #1;
    check("dual_busy_same", 64'(bus.busy_mask), 64'b0011);
    tick();
    check("dual_busy_next", 64'(bus.busy_mask), 64'b0000);
    check("dual_comp",      64'(bus.complete_count), 64'd2);
    check("dual_err",       64'(bus.err_spurious), 64'd0);

    // Spurious done on idle bank 3: sticky error, nothing else moves
    do_reset();
    bus.bank_done = 4'b1000;
    tick();
    check("spur_err",  64'(bus.err_spurious), 64'd1);
    check("spur_comp", 64'(bus.complete_count), 64'd0);
    check("spur_busy", 64'(bus.busy_mask), 64'd0);
    tick();
    tick();
    check("spur_sticky", 64'(bus.err_spurious), 64'd1);

    // Pop data withheld in WAIT: back to IDLE, no start, gid kept in FIFO
    do_reset();
    withhold = 1'b1;
    push(16'h0033);
    tick();
    check("wh_pop_ready_pop",  64'(bus.fifo_pop_ready), 64'd1);
    tick();
    check("wh_pop_ready_wait", 64'(bus.fifo_pop_ready), 64'd0);
    tick();
    check("wh_start", 64'(bus.bank_start), 64'd0);
    check("wh_disp",  64'(bus.dispatch_count), 64'd0);
    check("wh_busy",  64'(bus.busy_mask), 64'd0);
    withhold = 1'b0;
    wait_start(10, s, cyc);
    check("wh_retry_start", 64'(s), 64'b0001);
    check("wh_retry_lat",   64'(cyc), 64'd3);
    check("wh_retry_gid",   64'(slice(0)), 64'h0033);

    // Five gids: banks 0..3 fill, fifth stalls until bank 2 completes
    do_reset();
    push(16'h00a1);
    push(16'h00a2);
    push(16'h00a3);
    push(16'h00a4);
    push(16'h00a5);
    wait_start(10, s, cyc);
    check("five_s0", 64'(s), 64'b0001);
    wait_start(10, s, cyc);
    check("five_s1", 64'(s), 64'b0010);
    wait_start(10, s, cyc);
    check("five_s2", 64'(s), 64'b0100);
    wait_start(10, s, cyc);
    check("five_s3", 64'(s), 64'b1000);
    check("five_g3", 64'(slice(3)), 64'h00a4);
    any_start = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      any_start = any_start | bus.bank_start;
    end
    check("stall_no_start", 64'(any_start), 64'd0);
    check("stall_busy",     64'(bus.busy_mask), 64'b1111);
    check("stall_disp",     64'(bus.dispatch_count), 64'd4);
    check("stall_g2_stable", 64'(slice(2)), 64'h00a3);
    check("stall_fifo_empty", 64'(fifo_q.size()), 64'd0);

    bus.bank_done = 4'b0100;
    #1;
    check("done_cycle_no_start", 64'(bus.bank_start), 64'd0);
    tick();
    check("late_start",   64'(bus.bank_start), 64'b0100);
    check("late_gid",     64'(slice(2)), 64'h00a5);
    check("late_busy",    64'(bus.busy_mask), 64'b1011);
    check("late_comp",    64'(bus.complete_count), 64'd1);
    tick();
    check("late_busy_set", 64'(bus.busy_mask), 64'b1111);
    check("late_disp",     64'(bus.dispatch_count), 64'd5);

    // Sixth gid stalls in DISPATCH with every bank busy, then async reset
    push(16'h00a6);
    any_start = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      any_start = any_start | bus.bank_start;
    end
    check("six_no_start", 64'(any_start), 64'd0);
    check("six_busy",     64'(bus.busy_mask), 64'b1111);
    rst_n = 1'b0;
    #1;
    check("arst_pop_ready", 64'(bus.fifo_pop_ready), 64'd0);
    check("arst_start",     64'(bus.bank_start), 64'd0);
    check("arst_gid",       64'(bus.bank_gid), 64'd0);
    check("arst_busy",      64'(bus.busy_mask), 64'd0);
    check("arst_disp",      64'(bus.dispatch_count), 64'd0);
    check("arst_comp",      64'(bus.complete_count), 64'd0);
    check("arst_err",       64'(bus.err_spurious), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Done in the first cycle after release hits a bank that is no longer busy
    bus.bank_done = 4'b0100;
    tick();
    check("post_rst_err",  64'(bus.err_spurious), 64'd1);
    check("post_rst_busy", 64'(bus.busy_mask), 64'd0);
    check("post_rst_comp", 64'(bus.complete_count), 64'd0);
    tick();
    tick();
    check("post_rst_idle_pop",   64'(bus.fifo_pop_ready), 64'd0);
    check("post_rst_idle_start", 64'(bus.bank_start), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/group_dispatcher.md
GROUP_DISPATCHER -- requirements
Module: group_dispatcher

Interface
REQ-001 Parameter BANKS, default 4, number of downstream bank engines (power of two, >=2).
REQ-002 Parameter GID_WIDTH, default 16, group-id width.
REQ-003 Parameter CNT_WIDTH, default 32, dispatch/complete counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 fifo_peek_valid  input  1  upstream group FIFO non-empty.
REQ-007 fifo_pop_ready  output  1  one-cycle pop request to group FIFO.
REQ-008 fifo_pop_valid  input  1  popped gid valid, one cycle after accepted pop_ready.
REQ-009 fifo_pop_gid  input  GID_WIDTH  popped gid.
REQ-010 bank_start  output  BANKS  one-cycle start pulse per bank.
REQ-011 bank_gid  output  BANKS*GID_WIDTH  per-bank gid, slice b = bits [b*GID_WIDTH +: GID_WIDTH].
REQ-012 bank_done  input  BANKS  one-cycle completion pulse per bank.
REQ-013 busy_mask  output  BANKS  bank b holds an outstanding group.
REQ-014 dispatch_count  output  CNT_WIDTH  groups started since reset, wraps.
REQ-015 complete_count  output  CNT_WIDTH  valid completions since reset, wraps.
REQ-016 err_spurious  output  1  sticky: bank_done seen on a non-busy bank.

Function
REQ-017 FSM states SHALL be IDLE, POP, WAIT, DISPATCH.
REQ-018 IDLE: if fifo_peek_valid, go POP; else stay.
REQ-019 POP: fifo_pop_ready=1 for exactly this cycle; go WAIT unconditionally.
REQ-020 WAIT: if fifo_pop_valid, capture fifo_pop_gid into hold register and go DISPATCH; else go IDLE (no gid lost, no counter change).
REQ-021 fifo_pop_ready SHALL be 1 only in POP; it is registered-state-decoded, never combinationally from fifo_peek_valid.
REQ-022 DISPATCH: idle set = ~busy_mask; select first idle bank scanning from rr_ptr upward, wrapping modulo BANKS.
REQ-023 If an idle bank b exists: bank_start[b]=1 that cycle, bank_gid slice b <= hold gid, busy_mask[b] set next cycle, rr_ptr <= (b+1) mod BANKS, dispatch_count +1, go IDLE.
REQ-024 If no idle bank: stay in DISPATCH holding gid, no start pulse.
REQ-025 At most one bank_start bit SHALL be high in any cycle.
REQ-026 bank_gid slice b SHALL remain stable from start until the cycle after its bank_done.
REQ-027 bank_done[b] with busy_mask[b]=1 clears busy_mask[b] next cycle and increments complete_count (popcount of valid done bits, multiple same cycle allowed).
REQ-028 A bank whose done arrives this cycle SHALL NOT be eligible for dispatch until the following cycle.
REQ-029 bank_done[b] with busy_mask[b]=0 sets err_spurious; busy_mask and counters unchanged.
REQ-030 Counters SHALL wrap modulo 2^CNT_WIDTH without flag.
REQ-031 Minimum per-group throughput: 4 cycles (IDLE-POP-WAIT-DISPATCH).

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, fifo_pop_ready 0, bank_start 0, bank_gid 0, busy_mask 0, rr_ptr 0, hold gid 0, dispatch_count 0, complete_count 0, err_spurious 0.
REQ-033 Reset mid-dispatch SHALL drop the held gid and all outstanding busy bits; bank_done arriving in the first cycle after reset release SHALL set err_spurious.

Structure
REQ-034 FSM state encoding and the default parameter constants SHALL live in the shared group package alongside the group FIFO constants.
REQ-035 The rotating first-idle selection SHALL be a sub-module rr_idle_select (inputs idle mask, rr_ptr; outputs found, index).

Verification
REQ-036 FIFO loaded with gids 0x0011,0x0022, all banks idle -> bank_start[0] with 0x0011, then bank_start[1] with 0x0022; dispatch_count=2.
REQ-037 Five gids, no bank_done -> banks 0..3 started, FSM stalls in DISPATCH holding 5th gid; done on bank 2 -> 5th gid starts on bank 2 one cycle after done, not same cycle.
REQ-038 fifo_peek_valid high but fifo_pop_valid withheld in WAIT -> return to IDLE, no start, counts unchanged.
REQ-039 bank_done[3] with busy_mask=0 -> err_spurious=1 and stays 1; complete_count 0.
REQ-040 Simultaneous bank_done on banks 0 and 1 (both busy) -> complete_count +2, busy_mask bits cleared next cycle.
REQ-041 rst_n asserted while busy_mask=4'b1111 and FSM in DISPATCH -> all outputs zero immediately, FSM IDLE.
